// File: rtl/axil_pkg.sv
// rtl/axil_pkg.sv - shared FSM states and AXI response codes for the AXI4-Lite initiator
package axil_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    DONE    = 3'd5
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi4_lite_if.sv
// rtl/axi4_lite_if.sv - AXI4-Lite signal bundle with master and slave views
interface axi4_lite_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          awvalid, awready;
  logic [AW-1:0] awaddr;
  logic [2:0]    awprot;
  logic          wvalid, wready;
  logic [DW-1:0] wdata;
  logic [DW/8-1:0] wstrb;
  logic          bvalid, bready;
  logic [1:0]    bresp;
  logic          arvalid, arready;
  logic [AW-1:0] araddr;
  logic [2:0]    arprot;
  logic          rvalid, rready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;

  modport master (
    output awvalid, awaddr, awprot, input awready,
    output wvalid, wdata, wstrb, input wready,
    input bvalid, bresp, output bready,
    output arvalid, araddr, arprot, input arready,
    input rvalid, rdata, rresp, output rready
  );

  modport slave (
    input awvalid, awaddr, awprot, output awready,
    input wvalid, wdata, wstrb, output wready,
    output bvalid, bresp, input bready,
    input arvalid, araddr, arprot, output arready,
    output rvalid, rdata, rresp, input rready
  );
endinterface

// File: rtl/axil_initiator.sv
// rtl/axil_initiator.sv - single-outstanding AXI4-Lite initiator with command/response ports
module axil_initiator
  import axil_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 32,
  parameter int LW = 16
) (
  input  logic            aclk,
  input  logic            aresetn,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_we,
  input  logic [AW-1:0]   cmd_addr,
  input  logic [DW-1:0]   cmd_wdata,
  input  logic [DW/8-1:0] cmd_wstrb,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [DW-1:0]   rsp_rdata,
  output logic [1:0]      rsp_resp,
  output logic [LW-1:0]   rsp_latency,
  axi4_lite_if.master     axi
);

  state_e          state_q, state_d;
  logic            aw_done_q, aw_done_d;
  logic            w_done_q, w_done_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW/8-1:0] wstrb_q, wstrb_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [1:0]      resp_q, resp_d;
  logic [LW-1:0]   lat_q, lat_d, lat_inc;
  logic            aw_hs, w_hs, b_hs, ar_hs, r_hs;

  assign aw_hs   = axi.awvalid && axi.awready;
  assign w_hs    = axi.wvalid && axi.wready;
  assign b_hs    = axi.bvalid && axi.bready;
  assign ar_hs   = axi.arvalid && axi.arready;
  assign r_hs    = axi.rvalid && axi.rready;
  assign lat_inc = (lat_q == '1) ? lat_q : lat_q + 1'b1;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      resp_q    <= '0;
      lat_q     <= '0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      lat_q     <= lat_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    lat_d     = lat_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d    = cmd_addr;
          wdata_d   = cmd_wdata;
          wstrb_d   = cmd_wstrb;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          lat_d     = '0;
          state_d   = cmd_we ? WR_REQ : RD_REQ;
        end
      end
      WR_REQ: begin
        // AW and W complete independently; leave only once both have been taken
        lat_d = lat_inc;
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = WR_RESP;
      end
      WR_RESP: begin
        lat_d = lat_inc;
        if (b_hs) begin
          resp_d  = axi.bresp;
          rdata_d = '0;
          state_d = DONE;
        end
      end
      RD_REQ: begin
        lat_d = lat_inc;
        if (ar_hs) state_d = RD_RESP;
      end
      RD_RESP: begin
        lat_d = lat_inc;
        if (r_hs) begin
          rdata_d = axi.rdata;
          resp_d  = axi.rresp;
          state_d = DONE;
        end
      end
      DONE: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    // Gated with the reset pin so cmd_ready reads 0 while reset is held
    cmd_ready   = aresetn && (state_q == IDLE);
    rsp_valid   = (state_q == DONE);
    rsp_rdata   = rdata_q;
    rsp_resp    = resp_q;
    rsp_latency = lat_q;
    axi.awvalid = (state_q == WR_REQ) && !aw_done_q;
    axi.wvalid  = (state_q == WR_REQ) && !w_done_q;
    axi.bready  = (state_q == WR_RESP);
    axi.arvalid = (state_q == RD_REQ);
    axi.rready  = (state_q == RD_RESP);
    axi.awaddr  = addr_q;
    axi.awprot  = 3'b000;
    axi.wdata   = wdata_q;
    axi.wstrb   = wstrb_q;
    axi.araddr  = addr_q;
    axi.arprot  = 3'b000;
  end

endmodule

// File: tb/tb_axil_initiator.sv
// tb/tb_axil_initiator.sv - directed vector bench for axil_initiator
module tb_axil_initiator;
  import axil_pkg::*;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  int checks = 0;
  int failures = 0;

  logic        cmd_valid = 1'b0, cmd_we = 1'b0, rsp_ready = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        cmd_ready, rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [15:0] rsp_latency;

  logic        c4_valid = 1'b0, rsp_ready4 = 1'b0, b4_valid = 1'b0;
  logic        cmd_ready4, rsp_valid4;
  logic [31:0] rsp_rdata4;
  logic [1:0]  rsp_resp4;
  logic [3:0]  rsp_latency4;

  axi4_lite_if #(.AW(32), .DW(32)) ax ();
  axi4_lite_if #(.AW(32), .DW(32)) ax4 ();

  axil_initiator #(.DW(32), .AW(32), .LW(16)) u_dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_latency(rsp_latency), .axi(ax)
  );

  axil_initiator #(.DW(32), .AW(32), .LW(4)) u_dut4 (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(c4_valid), .cmd_ready(cmd_ready4), .cmd_we(1'b1),
    .cmd_addr(32'h0000_0040), .cmd_wdata(32'h1111_2222), .cmd_wstrb(4'hF),
    .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready4), .rsp_rdata(rsp_rdata4),
    .rsp_resp(rsp_resp4), .rsp_latency(rsp_latency4), .axi(ax4)
  );

  // Slave for the LW=4 instance: address/data always ready, B driven by the test
  assign ax4.awready = 1'b1;
  assign ax4.wready  = 1'b1;
  assign ax4.arready = 1'b1;
  assign ax4.bvalid  = b4_valid;
  assign ax4.bresp   = RESP_OKAY;
  assign ax4.rvalid  = 1'b0;
  assign ax4.rdata   = '0;
  assign ax4.rresp   = RESP_OKAY;

  // Configurable-delay slave for the main instance
  int aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
  logic [31:0] s_rdata = '0;
  logic [1:0]  s_resp = '0;
  int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;
  logic aw_seen = 1'b0, w_seen = 1'b0, ar_seen = 1'b0;

  assign ax.awready = ax.awvalid && (aw_cnt >= aw_dly);
  assign ax.wready  = ax.wvalid && (w_cnt >= w_dly);
  assign ax.arready = ax.arvalid && (ar_cnt >= ar_dly);
  assign ax.bvalid  = aw_seen && w_seen && (b_cnt >= b_dly);
  assign ax.rvalid  = ar_seen && (r_cnt >= r_dly);
  assign ax.bresp   = s_resp;
  assign ax.rresp   = s_resp;
  assign ax.rdata   = s_rdata;

  always @(posedge aclk) begin
    if (!aresetn) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
      aw_seen <= 1'b0; w_seen <= 1'b0; ar_seen <= 1'b0;
    end else begin
      aw_cnt <= (ax.awvalid && !ax.awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (ax.wvalid && !ax.wready) ? w_cnt + 1 : 0;
      ar_cnt <= (ax.arvalid && !ax.arready) ? ar_cnt + 1 : 0;
      if (ax.awvalid && ax.awready) aw_seen <= 1'b1;
      if (ax.wvalid && ax.wready) w_seen <= 1'b1;
      if (ax.arvalid && ax.arready) ar_seen <= 1'b1;
      if (ax.bvalid && ax.bready) begin
        aw_seen <= 1'b0; w_seen <= 1'b0; b_cnt <= 0;
      end else if (aw_seen && w_seen && !ax.bvalid) b_cnt <= b_cnt + 1;
      if (ax.rvalid && ax.rready) begin
        ar_seen <= 1'b0; r_cnt <= 0;
      end else if (ar_seen && !ax.rvalid) r_cnt <= r_cnt + 1;
    end
  end

  // Mid-cycle monitor: VALID-high cycle counts, payload against expectation, response count
  logic [31:0] exp_addr = '0, exp_wdata = '0;
  logic [3:0]  exp_wstrb = '0;
  int aw_hi_tot = 0, w_hi_tot = 0, ar_hi_tot = 0, pay_err_tot = 0, rsp_rise_tot = 0;
  logic prev_rsp_valid = 1'b0;

  always @(negedge aclk) begin
    prev_rsp_valid <= rsp_valid;
    if (rsp_valid && !prev_rsp_valid) rsp_rise_tot <= rsp_rise_tot + 1;
    if (ax.awvalid) aw_hi_tot <= aw_hi_tot + 1;
    if (ax.wvalid)  w_hi_tot  <= w_hi_tot + 1;
    if (ax.arvalid) ar_hi_tot <= ar_hi_tot + 1;
    if ((ax.awvalid && (ax.awaddr !== exp_addr || ax.awprot !== 3'b000)) ||
        (ax.wvalid && (ax.wdata !== exp_wdata || ax.wstrb !== exp_wstrb)) ||
        (ax.arvalid && (ax.araddr !== exp_addr || ax.arprot !== 3'b000)))
      pay_err_tot <= pay_err_tot + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          aw_d, w_d, ar_d, b_d, r_d;
    logic [31:0] s_rdata;
    logic [1:0]  s_resp;
    logic [31:0] e_rdata;
    logic [1:0]  e_resp;
    int          e_lat, e_aw, e_w, e_ar;
  } vec_t;

  vec_t vecs[7];

  task automatic run_vec(input int id, input vec_t v, input int stall);
    int aw0, w0, ar0, pe0, rr0, n;
    aw_dly = v.aw_d; w_dly = v.w_d; ar_dly = v.ar_d; b_dly = v.b_d; r_dly = v.r_d;
    s_rdata = v.s_rdata; s_resp = v.s_resp;
    exp_addr = v.addr; exp_wdata = v.wdata; exp_wstrb = v.wstrb;
    aw0 = aw_hi_tot; w0 = w_hi_tot; ar0 = ar_hi_tot; pe0 = pay_err_tot; rr0 = rsp_rise_tot;
    chk($sformatf("v%0d_cmd_ready_idle", id), 64'(cmd_ready), 64'(1));
    cmd_valid = 1'b1; cmd_we = v.we; cmd_addr = v.addr; cmd_wdata = v.wdata; cmd_wstrb = v.wstrb;
    tick();
    cmd_valid = 1'b0; cmd_addr = 32'hBAD0_BAD0; cmd_wdata = 32'h5A5A_5A5A;
    n = 0;
    while (!rsp_valid && n < 200) begin
      tick();
      n++;
    end
    chk($sformatf("v%0d_rsp_valid_seen", id), 64'(rsp_valid), 64'(1));
    chk($sformatf("v%0d_rdata", id), 64'(rsp_rdata), 64'(v.e_rdata));
    chk($sformatf("v%0d_resp", id), 64'(rsp_resp), 64'(v.e_resp));
    chk($sformatf("v%0d_latency", id), 64'(rsp_latency), 64'(v.e_lat));
    for (int s = 0; s < stall; s++) begin
      cmd_valid = 1'b1; cmd_we = 1'b0;
      tick();
      chk($sformatf("v%0d_stall%0d", id, s),
          {rsp_valid, cmd_ready, ax.awvalid, ax.wvalid, ax.arvalid, rsp_resp, rsp_rdata, rsp_latency},
          {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, v.e_resp, v.e_rdata, 16'(v.e_lat)});
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk($sformatf("v%0d_after_ack", id), {62'b0, rsp_valid, cmd_ready}, 64'b01);
    chk($sformatf("v%0d_aw_hi_cycles", id), 64'(aw_hi_tot - aw0), 64'(v.e_aw));
    chk($sformatf("v%0d_w_hi_cycles", id), 64'(w_hi_tot - w0), 64'(v.e_w));
    chk($sformatf("v%0d_ar_hi_cycles", id), 64'(ar_hi_tot - ar0), 64'(v.e_ar));
    chk($sformatf("v%0d_payload_errs", id), 64'(pay_err_tot - pe0), 64'(0));
    chk($sformatf("v%0d_rsp_count", id), 64'(rsp_rise_tot - rr0), 64'(1));
  endtask

  initial begin
    int n, rr0, bad;
    //         we     addr          wdata         strb  aw w ar b r  s_rdata       s_resp       e_rdata       e_resp       lat aw w ar
    vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 1, 0, 32'hFFFF_FFFF, RESP_OKAY,   32'h0,        RESP_OKAY,   3, 1, 1, 0};
    vecs[1] = '{1'b0, 32'h0000_0020, 32'h0,         4'h0, 0, 0, 0, 0, 2, 32'h1234_5678, RESP_SLVERR, 32'h1234_5678, RESP_SLVERR, 4, 0, 0, 1};
    vecs[2] = '{1'b1, 32'h0000_0044, 32'hCAFE_F00D, 4'h3, 0, 4, 0, 1, 0, 32'h5555_5555, RESP_OKAY,   32'h0,        RESP_OKAY,   7, 1, 5, 0};
    vecs[3] = '{1'b1, 32'h0000_0080, 32'h0123_4567, 4'hC, 3, 0, 0, 0, 0, 32'h6666_6666, RESP_SLVERR, 32'h0,        RESP_SLVERR, 5, 4, 1, 0};
    vecs[4] = '{1'b0, 32'h0000_0030, 32'h0,         4'h0, 0, 0, 3, 0, 0, 32'hAABB_CCDD, RESP_OKAY,   32'hAABB_CCDD, RESP_OKAY,   5, 0, 0, 4};
    vecs[5] = '{1'b1, 32'h0000_00FC, 32'h0,         4'h1, 2, 2, 0, 2, 0, 32'h7777_7777, RESP_DECERR, 32'h0,        RESP_DECERR, 6, 3, 3, 0};
    vecs[6] = '{1'b0, 32'h0000_1000, 32'h0,         4'h0, 0, 0, 0, 0, 0, 32'h0F0F_0F0F, RESP_EXOKAY, 32'h0F0F_0F0F, RESP_EXOKAY, 2, 0, 0, 1};

    tick(); tick();
    chk("reset_outputs",
        {ax.awvalid, ax.wvalid, ax.arvalid, ax.bready, ax.rready, rsp_valid, cmd_ready, rsp_resp, rsp_rdata, rsp_latency},
        '0);
    @(negedge aclk);
    aresetn = 1'b1;
    tick();
    chk("cmd_ready_after_reset", 64'(cmd_ready), 64'(1));

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i], (i == 4) ? 10 : 0);

    // Latency saturation on the LW=4 instance while B is stalled
    c4_valid = 1'b1;
    tick();
    c4_valid = 1'b0;
    repeat (40) tick();
    chk("sat_no_early_rsp", 64'(rsp_valid4), 64'(0));
    b4_valid = 1'b1;
    n = 0;
    while (!rsp_valid4 && n < 10) begin
      tick();
      n++;
    end
    b4_valid = 1'b0;
    chk("sat_rsp_valid", 64'(rsp_valid4), 64'(1));
    chk("sat_latency", 64'(rsp_latency4), 64'(15));
    chk("sat_resp_rdata", {rsp_resp4, rsp_rdata4}, 64'(0));
    rsp_ready4 = 1'b1;
    tick();
    rsp_ready4 = 1'b0;
    chk("sat_cmd_ready_after", 64'(cmd_ready4), 64'(1));

    // Reset while waiting in RD_RESP: transaction abandoned, nothing reported
    ar_dly = 0; r_dly = 50; exp_addr = 32'h0000_0020; s_rdata = 32'hDEAD_0000;
    rr0 = rsp_rise_tot;
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h0000_0020;
    tick();
    cmd_valid = 1'b0;
    n = 0;
    while (!ax.rready && n < 20) begin
      tick();
      n++;
    end
    chk("rst_reached_rd_resp", 64'(ax.rready), 64'(1));
    tick(); tick();
    #2 aresetn = 1'b0;
    #1;
    chk("rst_mid_outputs",
        {ax.awvalid, ax.wvalid, ax.arvalid, ax.bready, ax.rready, rsp_valid, cmd_ready, rsp_latency},
        '0);
    @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    tick();
    chk("rst_cmd_ready_next_cycle", 64'(cmd_ready), 64'(1));
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      if (rsp_valid || ax.rready || ax.arvalid) bad++;
      tick();
    end
    chk("rst_no_activity", 64'(bad), 64'(0));
    chk("rst_no_response", 64'(rsp_rise_tot - rr0), 64'(0));

    run_vec(7, vecs[1], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
